// File: rtl/regfile_access_sequencer_if.sv
// Handshake and control bundle between the instruction source and the
// register-file/ALU sequencer.
interface regfile_access_sequencer_if #(
    parameter int DW = 10,
    parameter int AW = 2
);
    logic          Exec;
    logic [DW-1:0] INSTR;
    logic          ENW;
    logic [AW-1:0] WRA;
    logic          ENR0;
    logic [AW-1:0] RDA0;
    logic          ENR1;
    logic [AW-1:0] RDA1;
    logic          ExtOut;
    logic          Ain;
    logic          Gin;
    logic          Gout;
    logic [3:0]    ALUcont;
    logic          Done;
    logic          Busy;

    modport master (
        output Exec, INSTR,
        input  ENW, WRA, ENR0, RDA0, ENR1, RDA1,
        input  ExtOut, Ain, Gin, Gout, ALUcont, Done, Busy
    );

    modport slave (
        input  Exec, INSTR,
        output ENW, WRA, ENR0, RDA0, ENR1, RDA1,
        output ExtOut, Ain, Gin, Gout, ALUcont, Done, Busy
    );
endinterface

// File: rtl/regfile_access_sequencer.sv
// Multi-cycle control sequencer for the 10-bit register-file datapath:
// captures one instruction on Exec and steps it through T1..T3.
module regfile_access_sequencer #(
    parameter int DW = 10,
    parameter int AW = 2
) (
    input  logic                        CLKb,
    input  logic                        Clear,
    regfile_access_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_ir;

    logic [3:0]    w_op;
    logic [AW-1:0] w_rx;
    logic [AW-1:0] w_ry;
    logic          w_is_load;
    logic          w_is_copy;
    logic          w_is_bin;
    logic          w_is_un;
    logic          w_unused_ir;

    logic          w_enw;
    logic [AW-1:0] w_wra;
    logic          w_enr0;
    logic [AW-1:0] w_rda0;
    logic          w_extout;
    logic          w_ain;
    logic          w_gin;
    logic          w_gout;
    logic          w_done;

    assign w_op        = r_ir[3:0];
    assign w_rx        = r_ir[DW-1 -: AW];
    assign w_ry        = r_ir[DW-AW-1 -: AW];
    assign w_unused_ir = ^r_ir[DW-2*AW-1:4];

    assign w_is_load = (w_op == 4'd0);
    assign w_is_copy = (w_op == 4'd1);
    assign w_is_bin  = (w_op >= 4'd2) && (w_op <= 4'd6);
    assign w_is_un   = (w_op == 4'd7) || (w_op == 4'd8);

    // Clear aborts mid-instruction; IR is only loaded from IDLE.
    always_ff @(posedge CLKb) begin
        if (Clear) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && bus.Exec) begin
                r_ir <= bus.INSTR;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_enw    = 1'b0;
        w_wra    = '0;
        w_enr0   = 1'b0;
        w_rda0   = '0;
        w_extout = 1'b0;
        w_ain    = 1'b0;
        w_gin    = 1'b0;
        w_gout   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Exec) begin
                    w_next = S_T1;
                end
            end
            S_T1: begin
                if (w_is_load) begin
                    w_extout = 1'b1;
                    w_enw    = 1'b1;
                    w_wra    = w_rx;
                    w_done   = 1'b1;
                    w_next   = S_IDLE;
                end else if (w_is_copy) begin
                    w_enr0   = 1'b1;
                    w_rda0   = w_ry;
                    w_enw    = 1'b1;
                    w_wra    = w_rx;
                    w_done   = 1'b1;
                    w_next   = S_IDLE;
                end else if (w_is_bin) begin
                    // Rx is latched into A here, before any write-back, so Rx=Ry is safe.
                    w_enr0   = 1'b1;
                    w_rda0   = w_rx;
                    w_ain    = 1'b1;
                    w_next   = S_T2;
                end else if (w_is_un) begin
                    w_gin    = 1'b1;
                    w_next   = S_T2;
                end else begin
                    w_done   = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            S_T2: begin
                if (w_is_bin) begin
                    w_gin    = 1'b1;
                    w_next   = S_T3;
                end else begin
                    w_gout   = 1'b1;
                    w_enw    = 1'b1;
                    w_wra    = w_rx;
                    w_done   = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            S_T3: begin
                w_gout   = 1'b1;
                w_enw    = 1'b1;
                w_wra    = w_rx;
                w_done   = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.ENW     = w_enw;
    assign bus.WRA     = w_wra;
    assign bus.ENR0    = w_enr0;
    assign bus.RDA0    = w_rda0;
    assign bus.ENR1    = 1'b1;
    assign bus.RDA1    = w_ry;
    assign bus.ExtOut  = w_extout;
    assign bus.Ain     = w_ain;
    assign bus.Gin     = w_gin;
    assign bus.Gout    = w_gout;
    assign bus.ALUcont = w_op;
    assign bus.Done    = w_done;
    assign bus.Busy    = (r_state != S_IDLE);

endmodule
